// File: rtl/dma_stats_pkg.sv
// ----------------------------------------------------------------------------
// dma_stats_pkg : shared limits, channel event encoding and counter increment
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dma_stats_pkg;

  localparam int MAX_CH    = 16;
  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 48;
  localparam int CNT_IDX_W = 6;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_GOOD  = 2'd1,
    EV_DROP  = 2'd2,
    EV_CLEAR = 2'd3
  } chan_evt_e;

  // Returns {carry, sum} where sum is (val + 1) truncated to 'width' bits and
  // carry is bit 'width' of the full-precision sum. Bits above 'width' are zero.
  function automatic logic [MAX_WIDTH:0] inc_with_carry(
    input logic [MAX_WIDTH-1:0] val,
    input logic [CNT_IDX_W-1:0] width
  );
    logic [MAX_WIDTH:0]   one;
    logic [MAX_WIDTH:0]   sum;
    logic [MAX_WIDTH-1:0] mask;
    one  = {{MAX_WIDTH{1'b0}}, 1'b1};
    sum  = {1'b0, val} + one;
    mask = MAX_WIDTH'((one << width) - one);
    return {sum[width], sum[MAX_WIDTH-1:0] & mask};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_chan_counter.sv
// ----------------------------------------------------------------------------
// dma_chan_counter : one channel of accepted/dropped write counters with
//                    enable-edge clear, sticky overflow flags and shadow pair
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dma_chan_counter
  import dma_stats_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             chan_enable,
  input  logic             wr_en,
  input  logic             wr_overflow,
  input  logic             snap_req,
  output logic [WIDTH-1:0] good_count,
  output logic [WIDTH-1:0] drop_count,
  output logic [WIDTH-1:0] good_snap,
  output logic [WIDTH-1:0] drop_snap,
  output logic             good_ovf,
  output logic             drop_ovf
);

  logic             wr_en_q;
  logic             en_q;
  logic [WIDTH-1:0] good_q;
  logic [WIDTH-1:0] drop_q;
  logic [WIDTH-1:0] good_snap_q;
  logic [WIDTH-1:0] drop_snap_q;
  logic             good_ovf_q;
  logic             drop_ovf_q;

  logic [WIDTH-1:0] good_d;
  logic [WIDTH-1:0] drop_d;
  logic             good_ovf_d;
  logic             drop_ovf_d;

  logic [MAX_WIDTH:0] good_inc;
  logic [MAX_WIDTH:0] drop_inc;
  logic [WIDTH-1:0]   good_sum;
  logic [WIDTH-1:0]   drop_sum;
  logic               good_carry;
  logic               drop_carry;
  logic               unused_carry;
  chan_evt_e          evt;

  assign good_inc   = inc_with_carry(MAX_WIDTH'(good_q), CNT_IDX_W'(WIDTH));
  assign drop_inc   = inc_with_carry(MAX_WIDTH'(drop_q), CNT_IDX_W'(WIDTH));
  assign good_sum   = good_inc[WIDTH-1:0];
  assign drop_sum   = drop_inc[WIDTH-1:0];
  assign good_carry = good_inc[MAX_WIDTH];
  assign drop_carry = drop_inc[MAX_WIDTH];

  // The carry is only consumed in wrap mode; the padding bits are always zero.
  assign unused_carry = good_carry ^ drop_carry;

  generate
    if (WIDTH < MAX_WIDTH) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^{good_inc[MAX_WIDTH-1:WIDTH], drop_inc[MAX_WIDTH-1:WIDTH]};
    end
  endgenerate

  // Clear wins over a write classified on the same edge.
  always_comb begin
    evt = EV_NONE;
    if (chan_enable && !en_q) begin
      evt = EV_CLEAR;
    end else if (wr_en_q) begin
      evt = wr_overflow ? EV_DROP : EV_GOOD;
    end
  end

  always_comb begin
    good_d     = good_q;
    drop_d     = drop_q;
    good_ovf_d = good_ovf_q;
    drop_ovf_d = drop_ovf_q;
    unique case (evt)
      EV_CLEAR: begin
        good_d     = '0;
        drop_d     = '0;
        good_ovf_d = 1'b0;
        drop_ovf_d = 1'b0;
      end
      EV_GOOD: begin
        if (SATURATE) begin
          if (!(&good_q)) begin
            good_d     = good_sum;
            good_ovf_d = good_ovf_q | (&good_sum);
          end
        end else begin
          good_d     = good_sum;
          good_ovf_d = good_ovf_q | good_carry;
        end
      end
      EV_DROP: begin
        if (SATURATE) begin
          if (!(&drop_q)) begin
            drop_d     = drop_sum;
            drop_ovf_d = drop_ovf_q | (&drop_sum);
          end
        end else begin
          drop_d     = drop_sum;
          drop_ovf_d = drop_ovf_q | drop_carry;
        end
      end
      default: begin
      end
    endcase
  end

  // Shadows sample the live value from before this edge's update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q     <= 1'b0;
      en_q        <= 1'b0;
      good_q      <= '0;
      drop_q      <= '0;
      good_ovf_q  <= 1'b0;
      drop_ovf_q  <= 1'b0;
      good_snap_q <= '0;
      drop_snap_q <= '0;
    end else begin
      wr_en_q    <= wr_en;
      en_q       <= chan_enable;
      good_q     <= good_d;
      drop_q     <= drop_d;
      good_ovf_q <= good_ovf_d;
      drop_ovf_q <= drop_ovf_d;
      if (snap_req) begin
        good_snap_q <= good_q;
        drop_snap_q <= drop_q;
      end
    end
  end

  assign good_count = good_q;
  assign drop_count = drop_q;
  assign good_snap  = good_snap_q;
  assign drop_snap  = drop_snap_q;
  assign good_ovf   = good_ovf_q;
  assign drop_ovf   = drop_ovf_q;

endmodule

`default_nettype wire

// File: rtl/dma_write_stats.sv
// ----------------------------------------------------------------------------
// dma_write_stats : multi-channel DMA write statistics with coherent snapshot
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dma_write_stats
  import dma_stats_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       chan_enable,
  input  logic [NUM_CH-1:0]       wr_en,
  input  logic [NUM_CH-1:0]       wr_overflow,
  input  logic                    snap_req,
  output logic [NUM_CH*WIDTH-1:0] good_count,
  output logic [NUM_CH*WIDTH-1:0] drop_count,
  output logic [NUM_CH*WIDTH-1:0] good_snap,
  output logic [NUM_CH*WIDTH-1:0] drop_snap,
  output logic [NUM_CH-1:0]       good_ovf,
  output logic [NUM_CH-1:0]       drop_ovf,
  output logic                    snap_valid
);

  logic snap_valid_q;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      dma_chan_counter #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
      ) u_chan (
        .clk         (clk),
        .rstn        (rstn),
        .chan_enable (chan_enable[i]),
        .wr_en       (wr_en[i]),
        .wr_overflow (wr_overflow[i]),
        .snap_req    (snap_req),
        .good_count  (good_count[i*WIDTH +: WIDTH]),
        .drop_count  (drop_count[i*WIDTH +: WIDTH]),
        .good_snap   (good_snap[i*WIDTH +: WIDTH]),
        .drop_snap   (drop_snap[i*WIDTH +: WIDTH]),
        .good_ovf    (good_ovf[i]),
        .drop_ovf    (drop_ovf[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap_req;
    end
  end

  assign snap_valid = snap_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_write_stats.sv
// ----------------------------------------------------------------------------
// tb_dma_write_stats : wrap-mode 2-channel DUT plus a saturating 1-channel DUT
//                      fed from channel 0, both checked against an integer model
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dma_write_stats;

  localparam int NCH  = 2;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;
  localparam int NM   = 3;  // model slots: 0,1 = wrap DUT channels, 2 = saturating DUT

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NCH-1:0] chan_enable = '0;
  logic [NCH-1:0] wr_en = '0;
  logic [NCH-1:0] wr_overflow = '0;
  logic snap_req = 1'b0;

  logic [NCH*W-1:0] a_good, a_drop, a_gsnap, a_dsnap;
  logic [NCH-1:0]   a_govf, a_dovf;
  logic             a_sv;
  logic [W-1:0]     b_good, b_drop, b_gsnap, b_dsnap;
  logic             b_govf, b_dovf, b_sv;

  dma_write_stats #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk         (clk),
    .rstn        (rstn),
    .chan_enable (chan_enable),
    .wr_en       (wr_en),
    .wr_overflow (wr_overflow),
    .snap_req    (snap_req),
    .good_count  (a_good),
    .drop_count  (a_drop),
    .good_snap   (a_gsnap),
    .drop_snap   (a_dsnap),
    .good_ovf    (a_govf),
    .drop_ovf    (a_dovf),
    .snap_valid  (a_sv)
  );

  dma_write_stats #(.NUM_CH(1), .WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk         (clk),
    .rstn        (rstn),
    .chan_enable (chan_enable[0]),
    .wr_en       (wr_en[0]),
    .wr_overflow (wr_overflow[0]),
    .snap_req    (snap_req),
    .good_count  (b_good),
    .drop_count  (b_drop),
    .good_snap   (b_gsnap),
    .drop_snap   (b_dsnap),
    .good_ovf    (b_govf),
    .drop_ovf    (b_dovf),
    .snap_valid  (b_sv)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NCH-1:0] en_lvl = '0;

  int m_good [NM];
  int m_drop [NM];
  int m_gsnap[NM];
  int m_dsnap[NM];
  bit m_govf [NM];
  bit m_dovf [NM];
  bit m_pend [NM];
  bit m_enp  [NM];
  bit m_sv;

  function automatic int obs_good(int c);
    return (c == 2) ? int'(b_good) : int'(a_good[c*W +: W]);
  endfunction
  function automatic int obs_drop(int c);
    return (c == 2) ? int'(b_drop) : int'(a_drop[c*W +: W]);
  endfunction
  function automatic int obs_gsnap(int c);
    return (c == 2) ? int'(b_gsnap) : int'(a_gsnap[c*W +: W]);
  endfunction
  function automatic int obs_dsnap(int c);
    return (c == 2) ? int'(b_dsnap) : int'(a_dsnap[c*W +: W]);
  endfunction
  function automatic bit obs_govf(int c);
    return (c == 2) ? b_govf : a_govf[c];
  endfunction
  function automatic bit obs_dovf(int c);
    return (c == 2) ? b_dovf : a_dovf[c];
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NM; c++) begin
      m_good[c] = 0; m_drop[c] = 0; m_gsnap[c] = 0; m_dsnap[c] = 0;
      m_govf[c] = 0; m_dovf[c] = 0; m_pend[c] = 0; m_enp[c] = 0;
    end
    m_sv = 0;
  endfunction

  // Next value of a counter that saw one more event, in wrap or saturate mode.
  function automatic int next_val(bit sat, int v);
    if (sat) return (v < MAXV) ? v + 1 : v;
    return (v + 1) % (MAXV + 1);
  endfunction

  function automatic bit hit_ovf(bit sat, int v);
    if (sat) return (v == MAXV - 1);
    return (v == MAXV);
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NM; c++) begin
      int ch;
      bit sat;
      ch  = (c == 2) ? 0 : c;
      sat = (c == 2);
      if (snap_req) begin
        m_gsnap[c] = m_good[c];
        m_dsnap[c] = m_drop[c];
      end
      if (chan_enable[ch] && !m_enp[c]) begin
        m_good[c] = 0; m_drop[c] = 0; m_govf[c] = 0; m_dovf[c] = 0;
      end else if (m_pend[c]) begin
        if (wr_overflow[ch]) begin
          if (hit_ovf(sat, m_drop[c])) m_dovf[c] = 1;
          m_drop[c] = next_val(sat, m_drop[c]);
        end else begin
          if (hit_ovf(sat, m_good[c])) m_govf[c] = 1;
          m_good[c] = next_val(sat, m_good[c]);
        end
      end
      m_pend[c] = wr_en[ch];
      m_enp[c]  = chan_enable[ch];
    end
    m_sv = snap_req;
  endfunction

  task automatic step(input logic [NCH-1:0] wr, input logic [NCH-1:0] ov, input logic sn);
    wr_en       = wr;
    wr_overflow = ov;
    chan_enable = en_lvl;
    snap_req    = sn;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < NM; c++) begin
      checks++;
      if (obs_good(c) !== 0 || obs_drop(c) !== 0 || obs_gsnap(c) !== 0 ||
          obs_dsnap(c) !== 0 || obs_govf(c) !== 1'b0 || obs_dovf(c) !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold ch%0d: got good=%0d drop=%0d gsnap=%0d dsnap=%0d govf=%0b dovf=%0b expected all 0",
                 c, obs_good(c), obs_drop(c), obs_gsnap(c), obs_dsnap(c), obs_govf(c), obs_dovf(c));
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    step('0, '0, 1'b0);
    for (int c = 0; c < NM; c++) begin
      checks++;
      if (obs_good(c) !== 0 || obs_drop(c) !== 0 || obs_govf(c) !== 1'b0 || obs_dovf(c) !== 1'b0) begin
        errors++;
        $display("FAIL reset_release ch%0d: got good=%0d drop=%0d expected 0", c, obs_good(c), obs_drop(c));
      end
    end
    checks++;
    if (a_sv !== 1'b0 || b_sv !== 1'b0) begin
      errors++;
      $display("FAIL reset_snap_valid: got %0b/%0b expected 0/0", a_sv, b_sv);
    end
  endtask

  task automatic test_count();
    repeat (5) step(2'b01, 2'b00, 1'b0);
    repeat (2) step(2'b00, 2'b00, 1'b0);
    checks++;
    if (obs_good(0) !== 5 || obs_drop(0) !== 0) begin
      errors++;
      $display("FAIL count_ch0: got good=%0d drop=%0d expected 5/0", obs_good(0), obs_drop(0));
    end
    checks++;
    if (obs_good(1) !== 0 || obs_drop(1) !== 0) begin
      errors++;
      $display("FAIL count_ch1_idle: got good=%0d drop=%0d expected 0/0", obs_good(1), obs_drop(1));
    end
  endtask

  task automatic test_mixed_overflow();
    step(2'b10, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b10, 2'b10, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b10, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    checks++;
    if (obs_good(1) !== 2 || obs_drop(1) !== 2) begin
      errors++;
      $display("FAIL mixed_ch1: got good=%0d drop=%0d expected 2/2", obs_good(1), obs_drop(1));
    end
    checks++;
    if (obs_good(0) !== 5) begin
      errors++;
      $display("FAIL mixed_ch0_isolated: got good=%0d expected 5", obs_good(0));
    end
  endtask

  task automatic test_clear_priority();
    step(2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    checks++;
    if (obs_good(0) !== 7) begin
      errors++;
      $display("FAIL clear_pre ch0: got %0d expected 7", obs_good(0));
    end
    step(2'b01, 2'b00, 1'b0);
    en_lvl[0] = 1'b1;
    step(2'b00, 2'b00, 1'b0);
    for (int c = 0; c < NM; c += 2) begin
      checks++;
      if (obs_good(c) !== 0 || obs_drop(c) !== 0) begin
        errors++;
        $display("FAIL clear_priority slot%0d: got good=%0d drop=%0d expected 0/0", c, obs_good(c), obs_drop(c));
      end
    end
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    checks++;
    if (obs_good(0) !== 1 || obs_good(2) !== 1) begin
      errors++;
      $display("FAIL clear_after: got wrap=%0d sat=%0d expected 1/1", obs_good(0), obs_good(2));
    end
  endtask

  task automatic test_wrap_saturate();
    int n;
    int exp_a [3] = '{255, 0, 1};
    bit exp_af[3] = '{1'b0, 1'b1, 1'b1};
    n = 254 - m_good[0];
    repeat (n) step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    checks++;
    if (obs_good(0) !== 254 || obs_good(2) !== 254 || obs_govf(0) !== 1'b0 || obs_govf(2) !== 1'b0) begin
      errors++;
      $display("FAIL ws_254: got wrap=%0d sat=%0d ovf=%0b/%0b expected 254/254 0/0",
               obs_good(0), obs_good(2), obs_govf(0), obs_govf(2));
    end
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 2'b00, 1'b0);
      step(2'b00, 2'b00, 1'b0);
      checks++;
      if (obs_good(0) !== exp_a[k] || obs_govf(0) !== exp_af[k]) begin
        errors++;
        $display("FAIL ws_wrap write%0d: got %0d ovf=%0b expected %0d ovf=%0b",
                 k + 1, obs_good(0), obs_govf(0), exp_a[k], exp_af[k]);
      end
      checks++;
      if (obs_good(2) !== 255 || obs_govf(2) !== 1'b1) begin
        errors++;
        $display("FAIL ws_sat write%0d: got %0d ovf=%0b expected 255 ovf=1", k + 1, obs_good(2), obs_govf(2));
      end
    end
  endtask

  task automatic test_snapshot();
    en_lvl[0] = 1'b0;
    step(2'b00, 2'b00, 1'b0);
    en_lvl[0] = 1'b1;
    step(2'b00, 2'b00, 1'b0);
    repeat (11) step(2'b01, 2'b00, 1'b0);
    checks++;
    if (obs_good(0) !== 10) begin
      errors++;
      $display("FAIL snap_pre live: got %0d expected 10", obs_good(0));
    end
    step(2'b01, 2'b00, 1'b1);
    checks++;
    if (obs_gsnap(0) !== 10 || obs_gsnap(2) !== 10 || a_sv !== 1'b1 || b_sv !== 1'b1) begin
      errors++;
      $display("FAIL snap_capture: got snap=%0d/%0d valid=%0b/%0b expected 10/10 1/1",
               obs_gsnap(0), obs_gsnap(2), a_sv, b_sv);
    end
    checks++;
    if (obs_good(0) !== 11) begin
      errors++;
      $display("FAIL snap_live: got %0d expected 11", obs_good(0));
    end
    repeat (20) step(2'b01, 2'b00, 1'b0);
    checks++;
    if (obs_gsnap(0) !== 10 || a_sv !== 1'b0 || obs_good(0) !== 31) begin
      errors++;
      $display("FAIL snap_hold: got snap=%0d valid=%0b live=%0d expected 10 0 31",
               obs_gsnap(0), a_sv, obs_good(0));
    end
    step(2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 7) == 0) en_lvl[ch] = ~en_lvl[ch];
      step(NCH'($urandom), NCH'($urandom), ($urandom_range(0, 5) == 0));
      for (int c = 0; c < NM; c++) begin
        checks++;
        if (obs_good(c) !== m_good[c] || obs_drop(c) !== m_drop[c] ||
            obs_govf(c) !== m_govf[c] || obs_dovf(c) !== m_dovf[c]) begin
          errors++;
          $display("FAIL rnd_live cyc%0d slot%0d: got %0d/%0d ovf %0b/%0b expected %0d/%0d ovf %0b/%0b",
                   cyc, c, obs_good(c), obs_drop(c), obs_govf(c), obs_dovf(c),
                   m_good[c], m_drop[c], m_govf[c], m_dovf[c]);
        end
        checks++;
        if (obs_gsnap(c) !== m_gsnap[c] || obs_dsnap(c) !== m_dsnap[c]) begin
          errors++;
          $display("FAIL rnd_snap cyc%0d slot%0d: got %0d/%0d expected %0d/%0d",
                   cyc, c, obs_gsnap(c), obs_dsnap(c), m_gsnap[c], m_dsnap[c]);
        end
      end
      checks++;
      if (a_sv !== m_sv || b_sv !== m_sv) begin
        errors++;
        $display("FAIL rnd_snap_valid cyc%0d: got %0b/%0b expected %0b", cyc, a_sv, b_sv, m_sv);
      end
    end
  endtask

  task automatic test_async_reset();
    en_lvl = 2'b11;
    repeat (4) step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    for (int c = 0; c < NM; c++) begin
      checks++;
      if (obs_good(c) !== 0 || obs_drop(c) !== 0 || obs_gsnap(c) !== 0 ||
          obs_dsnap(c) !== 0 || obs_govf(c) !== 1'b0 || obs_dovf(c) !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_immediate slot%0d: got good=%0d drop=%0d gsnap=%0d expected 0",
                 c, obs_good(c), obs_drop(c), obs_gsnap(c));
      end
    end
    checks++;
    if (a_sv !== 1'b0 || b_sv !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_snap_valid: got %0b/%0b expected 0/0", a_sv, b_sv);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    wr_en       = '0;
    wr_overflow = '0;
    snap_req    = 1'b0;
    rstn        = 1'b1;
    repeat (2) step(2'b00, 2'b00, 1'b0);
    for (int c = 0; c < NM; c++) begin
      checks++;
      if (obs_good(c) !== m_good[c] || obs_drop(c) !== m_drop[c]) begin
        errors++;
        $display("FAIL async_reset_no_stray slot%0d: got %0d/%0d expected %0d/%0d",
                 c, obs_good(c), obs_drop(c), m_good[c], m_drop[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_mixed_overflow();
    test_clear_priority();
    test_wrap_saturate();
    test_snapshot();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
